// File: rtl/gpc_pkg.sv
// Shared constants and helpers for the gpc215 bit-heap compressor stages.
// The saturating adder is width-generic so later heap stages can reuse it.
package gpc_pkg;

    localparam int GPC215_SRC0_W = 5;
    localparam int GPC215_SRC1_W = 1;
    localparam int GPC215_SRC2_W = 2;
    localparam int GPC215_DST_W  = 4;
    localparam int GPC215_MAX    = 15;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } sat_res_t;

    // Adds two values and clamps the result to the all-ones value of a w-bit field.
    function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        sat_res_t    res;
        logic [32:0] sum;
        logic [32:0] max;
        max = (w >= 32) ? {1'b0, {32{1'b1}}} : ((33'd1 << w) - 33'd1);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > max) begin
            res.sat = 1'b1;
            res.val = max[31:0];
        end else begin
            res.sat = 1'b0;
            res.val = sum[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/gpc215_stream_accum_if.sv
// Beat input and packet-result output of the gpc215 stream accumulator.
// master = beat producer / result consumer, slave = accumulator.
interface gpc215_stream_accum_if
    import gpc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic [GPC215_SRC0_W-1:0] src0;
    logic [GPC215_SRC1_W-1:0] src1;
    logic [GPC215_SRC2_W-1:0] src2;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sum;
    logic [CNT_W-1:0]         out_count;
    logic                     out_ovf;

    modport master (
        output in_valid, src0, src1, src2, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, src0, src1, src2, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/gpc215_4.sv
// (5,1,2 -> 4) generalised parallel counter: dst = popcount(src0) + 2*src1 + 4*popcount(src2).
module gpc215_4
    import gpc_pkg::*;
(
    input  logic [GPC215_SRC0_W-1:0] src0,
    input  logic [GPC215_SRC1_W-1:0] src1,
    input  logic [GPC215_SRC2_W-1:0] src2,
    output logic [GPC215_DST_W-1:0]  dst
);

    logic [GPC215_DST_W-1:0] w1_sum;
    logic [GPC215_DST_W-1:0] w4_sum;

    assign w1_sum = 4'(src0[0]) + 4'(src0[1]) + 4'(src0[2]) + 4'(src0[3]) + 4'(src0[4]);
    assign w4_sum = 4'(src2[0]) + 4'(src2[1]);
    assign dst    = w1_sum + {2'b00, src1, 1'b0} + {w4_sum[1:0], 2'b00};

endmodule

// File: rtl/gpc215_stream_accum.sv
// Compresses each 5:1:2 heap slice to 0..15 and sums it over a packet, emitting
// a saturated total, beat count and overflow flag per packet.
module gpc215_stream_accum
    import gpc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    gpc215_stream_accum_if.slave   bus
);

    logic [GPC215_DST_W-1:0] gpc_dst;

    logic                    en_q;
    logic                    s1_valid_q, s1_valid_d;
    logic [GPC215_DST_W-1:0] s1_d_q, s1_d_d;
    logic                    s1_last_q, s1_last_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACC_W-1:0]        out_sum_q, out_sum_d;
    logic [CNT_W-1:0]        out_count_q, out_count_d;
    logic                    out_ovf_q, out_ovf_d;

    logic     in_ready;
    logic     in_fire;
    logic     out_fire;
    logic     s1_adv;
    logic     new_sat;
    sat_res_t sum_r;
    sat_res_t cnt_r;
    logic     sat_unused;

    gpc215_4 u_gpc (
        .src0 (bus.src0),
        .src1 (bus.src1),
        .src2 (bus.src2),
        .dst  (gpc_dst)
    );

    // Only a last beat waits for the result register; body beats always drain.
    assign out_fire = out_valid_q && bus.out_ready;
    assign s1_adv   = s1_valid_q && !(s1_last_q && out_valid_q && !bus.out_ready);
    assign in_ready = en_q && (!s1_valid_q || s1_adv);
    assign in_fire  = bus.in_valid && in_ready;

    assign sum_r      = sat_add(32'(acc_q), 32'(s1_d_q), ACC_W);
    assign cnt_r      = sat_add(32'(cnt_q), 32'd1, CNT_W);
    assign new_sat    = sum_r.sat | cnt_r.sat;
    assign sat_unused = ^{sum_r.val, cnt_r.val};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d_d      = s1_d_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_d_d     = gpc_dst;
            s1_last_d  = bus.in_last;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (s1_adv) begin
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_r.val[ACC_W-1:0];
                out_count_d = cnt_r.val[CNT_W-1:0];
                out_ovf_d   = ovf_q | new_sat;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = sum_r.val[ACC_W-1:0];
                cnt_d = cnt_r.val[CNT_W-1:0];
                ovf_d = ovf_q | new_sat;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_d_q      <= '0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            en_q        <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            s1_d_q      <= s1_d_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_gpc215_stream_accum.sv
// Scoreboard bench: three accumulators (default, narrow sum, narrow count) share one clock;
// stimulus pushes expected packet results, per-instance monitors pop and compare.
module tb_gpc215_stream_accum;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[3][$];

    logic       in_valid_v[3];
    logic       in_last_v[3];
    logic       out_ready_v[3];
    logic [4:0] src0_v[3];
    logic       src1_v[3];
    logic [1:0] src2_v[3];
    logic       in_ready_w[3];

    gpc215_stream_accum_if #(.ACC_W(16), .CNT_W(8)) if0 ();
    gpc215_stream_accum_if #(.ACC_W(4),  .CNT_W(8)) if1 ();
    gpc215_stream_accum_if #(.ACC_W(16), .CNT_W(2)) if2 ();

    gpc215_stream_accum #(.ACC_W(16), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gpc215_stream_accum #(.ACC_W(4),  .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    gpc215_stream_accum #(.ACC_W(16), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = in_valid_v[0];
    assign if0.in_last  = in_last_v[0];
    assign if0.src0     = src0_v[0];
    assign if0.src1     = src1_v[0];
    assign if0.src2     = src2_v[0];
    assign if0.out_ready = out_ready_v[0];
    assign in_ready_w[0] = if0.in_ready;

    assign if1.in_valid = in_valid_v[1];
    assign if1.in_last  = in_last_v[1];
    assign if1.src0     = src0_v[1];
    assign if1.src1     = src1_v[1];
    assign if1.src2     = src2_v[1];
    assign if1.out_ready = out_ready_v[1];
    assign in_ready_w[1] = if1.in_ready;

    assign if2.in_valid = in_valid_v[2];
    assign if2.in_last  = in_last_v[2];
    assign if2.src0     = src0_v[2];
    assign if2.src1     = src1_v[2];
    assign if2.src2     = src2_v[2];
    assign if2.out_ready = out_ready_v[2];
    assign in_ready_w[2] = if2.in_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic expect_result(input int k, input int s, input int c, input bit o);
        exp_t e;
        e.sum = 16'(s);
        e.cnt = 8'(c);
        e.ovf = o;
        sb[k].push_back(e);
    endtask

    // Compares a presented result against the scoreboard head; pops only when consumed.
    task automatic monitor(input int k, input logic v, input logic r,
                           input logic [15:0] s, input logic [7:0] c, input logic o);
        exp_t e;
        if (v === 1'b1) begin
            if (sb[k].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u%0d_unexpected_result actual_sum=%0d required=none", k, s);
            end else begin
                e = sb[k][0];
                check($sformatf("u%0d_sum", k),   32'(s), 32'(e.sum));
                check($sformatf("u%0d_count", k), 32'(c), 32'(e.cnt));
                check($sformatf("u%0d_ovf", k),   32'(o), 32'(e.ovf));
                if (r === 1'b1) void'(sb[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) monitor(0, if0.out_valid, if0.out_ready, if0.out_sum,
                                  if0.out_count, if0.out_ovf);
    always @(negedge clk) monitor(1, if1.out_valid, if1.out_ready, 16'(if1.out_sum),
                                  if1.out_count, if1.out_ovf);
    always @(negedge clk) monitor(2, if2.out_valid, if2.out_ready, if2.out_sum,
                                  8'(if2.out_count), if2.out_ovf);

    // Presents one beat and returns 1ns after the edge that accepted it.
    task automatic send(input int k, input logic [4:0] a, input logic b, input logic [1:0] c,
                        input logic last, output int waits);
        src0_v[k]     = a;
        src1_v[k]     = b;
        src2_v[k]     = c;
        in_last_v[k]  = last;
        in_valid_v[k] = 1'b1;
        waits = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready_w[k] === 1'b1) break;
            waits++;
            if (waits > 100) begin
                checks++;
                failures++;
                $display("FAIL u%0d_send_timeout actual=in_ready_low required=accept", k);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
    endtask

    initial begin
        int w;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid_v[k]  = 1'b0;
            in_last_v[k]   = 1'b0;
            out_ready_v[k] = 1'b1;
            src0_v[k]      = '0;
            src1_v[k]      = 1'b0;
            src2_v[k]      = '0;
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d_rst_in_ready", k), 32'(in_ready_w[k]), 32'd0);
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_out_sum",   32'(if0.out_sum),   32'd0);
        check("rst_out_count", 32'(if0.out_count), 32'd0);
        check("rst_out_ovf",   32'(if0.out_ovf),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d_post_rst_in_ready", k), 32'(in_ready_w[k]), 32'd1);

        // Single-beat packet and its one-cycle latency.
        expect_result(0, 8, 1, 1'b0);
        send(0, 5'h14, 1'b1, 2'h1, 1'b1, w);
        @(negedge clk);
        check("t1_valid_not_early", 32'(if0.out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid_latency", 32'(if0.out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Three back-to-back beats at full throughput.
        expect_result(0, 26, 3, 1'b0);
        send(0, 5'h1f, 1'b1, 2'h3, 1'b0, w);
        check("t2_b0_no_stall", 32'(w), 32'd0);
        send(0, 5'h00, 1'b0, 2'h0, 1'b0, w);
        check("t2_b1_no_stall", 32'(w), 32'd0);
        send(0, 5'h0d, 1'b0, 2'h3, 1'b1, w);
        check("t2_b2_no_stall", 32'(w), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Result held under backpressure; second last beat stalls behind it.
        out_ready_v[0] = 1'b0;
        expect_result(0, 3, 1, 1'b0);
        expect_result(0, 11, 1, 1'b0);
        send(0, 5'h04, 1'b1, 2'h0, 1'b1, w);
        send(0, 5'h19, 1'b0, 2'h3, 1'b1, w);
        check("t3_second_accepted", 32'(w), 32'd0);
        @(negedge clk);
        check("t3_last_stalls", 32'(in_ready_w[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready_v[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_drained", 32'(sb[0].size()), 32'd0);

        // Sum saturation at ACC_W=4, then overflow clears for the next packet.
        expect_result(1, 15, 2, 1'b1);
        send(1, 5'h1f, 1'b1, 2'h3, 1'b0, w);
        send(1, 5'h1f, 1'b1, 2'h3, 1'b1, w);
        expect_result(1, 4, 1, 1'b0);
        send(1, 5'h03, 1'b1, 2'h0, 1'b1, w);
        repeat (4) @(posedge clk);
        #1;

        // Count saturation at CNT_W=2 with zero-valued beats.
        expect_result(2, 0, 3, 1'b1);
        for (int i = 0; i < 5; i++)
            send(2, 5'h00, 1'b0, 2'h0, (i == 4), w);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-packet drops the partial accumulation.
        send(0, 5'h1f, 1'b1, 2'h3, 1'b0, w);
        send(0, 5'h1f, 1'b1, 2'h3, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_rst_out_valid", 32'(if0.out_valid), 32'd0);
        expect_result(0, 6, 1, 1'b0);
        send(0, 5'h03, 1'b0, 2'h1, 1'b1, w);
        repeat (6) @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++)
            check($sformatf("u%0d_scoreboard_empty", k), 32'(sb[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
